persiana_actuador: RTL and testbench
====================================

Name: persiana_actuador

Overview:
- Behavioural plant model of the blind motor and position-sensor assembly. It sits on the opposite side of the motor/sensor interface from the blind controller.
- Consumes the controller's motor commands `subir`/`bajar`. Integrates blind position with a step prescaler.
- Drives the limit/mid sensors `Ssup`/`Smed`/`Sinf` back to the controller.
- Used for closed-loop simulation and for on-chip hardware-in-loop demo builds. Flags illegal command combinations.

Parameters:
- PASOS_MAX, 200: full travel in steps. 0 = fully closed (bottom), PASOS_MAX = fully open (top). Range 2..255.
- PASO_MED, 100: step index where the mid sensor sits. Must satisfy 0 < PASO_MED < PASOS_MAX.
- PRESC, 1000: Reloj cycles per position step while moving. Range 1..65535.
- POS_INI, 0: position loaded on reset. Range 0..PASOS_MAX.

Ports:
- Reloj, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- subir, input, 1: motor-up command from the controller.
- bajar, input, 1: motor-down command from the controller.
- Ssup, output, 1: top limit sensor. 1 when posicion == PASOS_MAX.
- Smed, output, 1: mid sensor. 1 when posicion == PASO_MED.
- Sinf, output, 1: bottom limit sensor. 1 when posicion == 0.
- posicion, output, 8: current step position, unsigned.
- moviendo, output, 1: 1 while in SUBIENDO or BAJANDO.
- falla, output, 1: sticky fault flag.

Behaviour:
- Reset (async, active-high):
  - State = REPOSO, posicion = POS_INI, prescaler = 0, falla = 0, moviendo = 0.
  - Sensors decode from POS_INI immediately.
- Sensors and moviendo are decoded from registered state/posicion only. They never combinationally depend on subir/bajar.
- Internal prescaler is 16 bits.
- States: REPOSO, SUBIENDO, BAJANDO, FALLA. Evaluated each rising edge of Reloj; priority is top-down:
  - subir=1 and bajar=1 in any non-FALLA state -> FALLA next cycle. posicion frozen, prescaler cleared.
  - REPOSO -> SUBIENDO if subir=1 and posicion<PASOS_MAX.
  - REPOSO -> BAJANDO if bajar=1 and posicion>0.
  - A command toward a limit already reached is ignored (stay REPOSO).
  - SUBIENDO -> REPOSO if subir=0 or posicion==PASOS_MAX. Same for BAJANDO with bajar=0 or posicion==0.
  - SUBIENDO <-> BAJANDO directly when the opposite single command is asserted and the target limit is not reached. Prescaler cleared.
  - FALLA is absorbing: falla=1, moviendo=0, posicion held. Exit only via reset.
- Prescaler:
  - Cleared on every state change.
  - In SUBIENDO/BAJANDO it counts +1 per cycle.
  - When it equals PRESC-1: posicion steps +1 (SUBIENDO) or -1 (BAJANDO) and the prescaler returns to 0.
  - First step therefore lands exactly PRESC cycles after the cycle the state is entered.
- Limits:
  - posicion never exceeds PASOS_MAX and never goes below 0; no wrap-around.
  - The step that reaches a limit makes the sensor assert on the same edge. The state leaves to REPOSO on the following edge.
- Command dropped mid-step: the prescaler count is discarded (REPOSO clears it). No partial step is retained.
- PRESC=1: one step per cycle while moving.

Test Plan (PASOS_MAX=10, PASO_MED=5, PRESC=4, POS_INI=0 unless noted):
- Reset -> posicion=0, Sinf=1, Ssup=0, Smed=0, moviendo=0, falla=0.
- Hold subir from cycle 0 -> moviendo=1 next edge; posicion=1 four cycles after SUBIENDO entry; Smed=1 at posicion=5 (20 cycles); Ssup=1 at posicion=10; REPOSO next edge; posicion stays 10 while subir held.
- From posicion=10, pulse bajar for 6 cycles then release -> exactly one step (posicion=9), Ssup=0, prescaler residue discarded, moviendo=0.
- While SUBIENDO at posicion=3, switch to bajar only -> BAJANDO next edge; posicion=2 four cycles later.
- Assert subir and bajar together at posicion=4 -> falla=1 next edge, posicion held at 4, commands ignored thereafter. Async reset mid-cycle clears falla and reloads posicion=0 without waiting for an edge.
- bajar with posicion=0 (and POS_INI=10 with subir) -> no state change, moviendo stays 0, no underflow/overflow.

Source files
------------

// File: rtl/persiana_actuador.sv
// persiana_actuador
// Behavioural plant model of a motorised blind: motor plus position sensors.
// It sits on the far side of the motor/sensor interface from the blind
// controller, so it closes the loop in simulation and in hardware-in-loop
// demo builds.
//
// Ports
//   Reloj     in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   subir     in   motor-up command from the controller
//   bajar     in   motor-down command from the controller
//   Ssup      out  top limit sensor    (posicion == PASOS_MAX)
//   Smed      out  mid sensor          (posicion == PASO_MED)
//   Sinf      out  bottom limit sensor (posicion == 0)
//   posicion  out  current step position, unsigned, 0 = fully closed
//   moviendo  out  motor running (SUBIENDO or BAJANDO)
//   falla     out  sticky fault: subir and bajar were asserted together
//
// State    | meaning
// ---------+---------------------------------------------------------
// REPOSO   | motor stopped, prescaler held at zero
// SUBIENDO | moving up, one step every PRESC cycles
// BAJANDO  | moving down, one step every PRESC cycles
// FALLA    | conflicting commands seen; absorbing until reset
//
// Every output comes from a flop. The sensors and moviendo are decoded from
// the next state and next position, so no output depends combinationally on
// subir or bajar.
module persiana_actuador #(
    parameter int PASOS_MAX = 200,
    parameter int PASO_MED  = 100,
    parameter int PRESC     = 1000,
    parameter int POS_INI   = 0
) (
    input  logic       Reloj,
    input  logic       reset,
    input  logic       subir,
    input  logic       bajar,
    output logic       Ssup,
    output logic       Smed,
    output logic       Sinf,
    output logic [7:0] posicion,
    output logic       moviendo,
    output logic       falla
);

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        SUBIENDO = 2'd1,
        BAJANDO  = 2'd2,
        FALLA    = 2'd3
    } estado_t;

    localparam logic [7:0]  POS_MAX_C = 8'(PASOS_MAX);
    localparam logic [7:0]  POS_MED_C = 8'(PASO_MED);
    localparam logic [7:0]  POS_INI_C = 8'(POS_INI);
    localparam logic [15:0] PRESC_TC  = 16'(PRESC - 1);

    estado_t     state_q, state_d;
    logic [7:0]  pos_q, pos_d;
    logic [15:0] presc_q, presc_d;
    logic        ssup_q, ssup_d;
    logic        smed_q, smed_d;
    logic        sinf_q, sinf_d;
    logic        moviendo_q, moviendo_d;
    logic        falla_q, falla_d;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        presc_d = presc_q;

        if (state_q == FALLA) begin
            // Absorbing: position frozen, only reset leaves.
            presc_d = '0;
        end else if (subir && bajar) begin
            state_d = FALLA;
            presc_d = '0;
        end else begin
            case (state_q)
                REPOSO: begin
                    // Any count left over from an interrupted step is dropped here.
                    presc_d = '0;
                    if (subir && (pos_q < POS_MAX_C)) begin
                        state_d = SUBIENDO;
                    end else if (bajar && (pos_q > 8'd0)) begin
                        state_d = BAJANDO;
                    end
                end
                SUBIENDO: begin
                    // A reversal goes straight to BAJANDO without a stop in REPOSO.
                    if (bajar && (pos_q > 8'd0)) begin
                        state_d = BAJANDO;
                        presc_d = '0;
                    end else if (!subir || (pos_q == POS_MAX_C)) begin
                        state_d = REPOSO;
                        presc_d = '0;
                    end else if (presc_q == PRESC_TC) begin
                        pos_d   = pos_q + 8'd1;
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + 16'd1;
                    end
                end
                BAJANDO: begin
                    if (subir && (pos_q < POS_MAX_C)) begin
                        state_d = SUBIENDO;
                        presc_d = '0;
                    end else if (!bajar || (pos_q == 8'd0)) begin
                        state_d = REPOSO;
                        presc_d = '0;
                    end else if (presc_q == PRESC_TC) begin
                        pos_d   = pos_q - 8'd1;
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + 16'd1;
                    end
                end
                default: begin
                    state_d = FALLA;
                    presc_d = '0;
                end
            endcase
        end

        // The step that reaches a limit asserts the sensor on that same edge.
        ssup_d     = (pos_d == POS_MAX_C);
        smed_d     = (pos_d == POS_MED_C);
        sinf_d     = (pos_d == 8'd0);
        moviendo_d = (state_d == SUBIENDO) || (state_d == BAJANDO);
        falla_d    = (state_d == FALLA);
    end

    always_ff @(posedge Reloj or posedge reset) begin
        if (reset) begin
            state_q    <= REPOSO;
            pos_q      <= POS_INI_C;
            presc_q    <= '0;
            ssup_q     <= (POS_INI_C == POS_MAX_C);
            smed_q     <= (POS_INI_C == POS_MED_C);
            sinf_q     <= (POS_INI_C == 8'd0);
            moviendo_q <= 1'b0;
            falla_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            presc_q    <= presc_d;
            ssup_q     <= ssup_d;
            smed_q     <= smed_d;
            sinf_q     <= sinf_d;
            moviendo_q <= moviendo_d;
            falla_q    <= falla_d;
        end
    end

    assign Ssup     = ssup_q;
    assign Smed     = smed_q;
    assign Sinf     = sinf_q;
    assign posicion = pos_q;
    assign moviendo = moviendo_q;
    assign falla    = falla_q;

endmodule

// File: tb/tb_persiana_actuador.sv
module tb_persiana_actuador;

    localparam int PMAX = 10;
    localparam int PMED = 5;
    localparam int PRE  = 4;

    logic       Reloj = 1'b0;
    logic       reset, subir, bajar;
    logic       Ssup, Smed, Sinf, moviendo, falla;
    logic [7:0] posicion;

    logic       reset2, subir2, bajar2;
    logic       Ssup2, Smed2, Sinf2, moviendo2, falla2;
    logic [7:0] posicion2;

    int errors = 0;
    int checks = 0;

    // Packed expectation: {posicion, Ssup, Smed, Sinf, moviendo, falla}
    typedef struct {
        string       name;
        logic [12:0] v;
    } exp_t;

    exp_t sb[$];

    persiana_actuador #(.PASOS_MAX(PMAX), .PASO_MED(PMED), .PRESC(PRE), .POS_INI(0)) dut (
        .Reloj(Reloj), .reset(reset), .subir(subir), .bajar(bajar),
        .Ssup(Ssup), .Smed(Smed), .Sinf(Sinf), .posicion(posicion),
        .moviendo(moviendo), .falla(falla)
    );

    persiana_actuador #(.PASOS_MAX(PMAX), .PASO_MED(PMED), .PRESC(PRE), .POS_INI(PMAX)) dut_top (
        .Reloj(Reloj), .reset(reset2), .subir(subir2), .bajar(bajar2),
        .Ssup(Ssup2), .Smed(Smed2), .Sinf(Sinf2), .posicion(posicion2),
        .moviendo(moviendo2), .falla(falla2)
    );

    always #5 Reloj = ~Reloj;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    function automatic logic [12:0] mk(input int pos, input bit mov, input bit fal);
        logic [7:0] p;
        p = 8'(pos);
        return {p, (pos == PMAX), (pos == PMED), (pos == 0), mov, fal};
    endfunction

    function automatic logic [12:0] obs1();
        return {posicion, Ssup, Smed, Sinf, moviendo, falla};
    endfunction

    function automatic logic [12:0] obs2();
        return {posicion2, Ssup2, Smed2, Sinf2, moviendo2, falla2};
    endfunction

    // Inputs change 1 ns after a rising edge; outputs are checked at the same point.
    task automatic edge_wait();
        @(posedge Reloj);
        #1;
    endtask

    task automatic do_reset();
        subir = 1'b0;
        bajar = 1'b0;
        reset = 1'b1;
        edge_wait();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset();
        sb.push_back('{"reset", mk(0, 0, 0)});
        e = sb.pop_front();
        checks++;
        if (obs1() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, obs1(), e.v);
        end
    endtask

    // Full travel from 0 to the top limit with subir held throughout.
    task automatic test_subida();
        exp_t e;
        int   p;
        do_reset();
        subir = 1'b1;
        for (int k = 1; k <= 46; k++) begin
            p = (k - 1) / PRE;
            if (p > PMAX) p = PMAX;
            sb.push_back('{$sformatf("subida edge %0d", k), mk(p, k <= 41, 0)});
            edge_wait();
            e = sb.pop_front();
            checks++;
            if (obs1() !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, obs1(), e.v);
            end
        end
    endtask

    // Starting at 10: six cycles of bajar give exactly one step, then a new
    // bajar must take a full PRE cycles again (no leftover prescaler count).
    task automatic test_bajar_pulso();
        exp_t e;
        subir = 1'b0;
        bajar = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            sb.push_back('{$sformatf("pulso edge %0d", k), mk((k >= 5) ? 9 : 10, 1, 0)});
            edge_wait();
            e = sb.pop_front();
            checks++;
            if (obs1() !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, obs1(), e.v);
            end
        end
        bajar = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            sb.push_back('{$sformatf("pulso idle %0d", k), mk(9, 0, 0)});
            edge_wait();
            e = sb.pop_front();
            checks++;
            if (obs1() !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, obs1(), e.v);
            end
        end
        bajar = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            sb.push_back('{$sformatf("rebajar edge %0d", k), mk((k >= 5) ? 8 : 9, 1, 0)});
            edge_wait();
            e = sb.pop_front();
            checks++;
            if (obs1() !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, obs1(), e.v);
            end
        end
        bajar = 1'b0;
        edge_wait();
    endtask

    // Reversal at position 3: BAJANDO is entered directly and steps after PRE cycles.
    task automatic test_inversion();
        exp_t e;
        do_reset();
        subir = 1'b1;
        repeat (13) edge_wait();
        sb.push_back('{"inversion at 3", mk(3, 1, 0)});
        e = sb.pop_front();
        checks++;
        if (obs1() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, obs1(), e.v);
        end
        subir = 1'b0;
        bajar = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            sb.push_back('{$sformatf("inversion edge %0d", k), mk((k >= 5) ? 2 : 3, 1, 0)});
            edge_wait();
            e = sb.pop_front();
            checks++;
            if (obs1() !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, obs1(), e.v);
            end
        end
        bajar = 1'b0;
    endtask

    // Both commands at position 4: sticky fault, then async reset mid-cycle.
    task automatic test_falla();
        exp_t e;
        do_reset();
        subir = 1'b1;
        repeat (17) edge_wait();
        bajar = 1'b1;
        sb.push_back('{"falla entry", mk(4, 0, 1)});
        edge_wait();
        e = sb.pop_front();
        checks++;
        if (obs1() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, obs1(), e.v);
        end
        for (int k = 0; k < 6; k++) begin
            subir = k[0];
            bajar = ~k[0];
            sb.push_back('{$sformatf("falla hold %0d", k), mk(4, 0, 1)});
            edge_wait();
            e = sb.pop_front();
            checks++;
            if (obs1() !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, obs1(), e.v);
            end
        end
        subir = 1'b0;
        bajar = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        sb.push_back('{"async reset", mk(0, 0, 0)});
        e = sb.pop_front();
        checks++;
        if (obs1() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, obs1(), e.v);
        end
        edge_wait();
        reset = 1'b0;
    endtask

    // Commands toward a limit already reached are ignored, on both ends.
    task automatic test_limites();
        exp_t e;
        do_reset();
        bajar = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            sb.push_back('{$sformatf("bajar at 0 edge %0d", k), mk(0, 0, 0)});
            edge_wait();
            e = sb.pop_front();
            checks++;
            if (obs1() !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, obs1(), e.v);
            end
        end
        bajar = 1'b0;

        subir2 = 1'b0;
        bajar2 = 1'b0;
        reset2 = 1'b1;
        #1;
        sb.push_back('{"top reset", mk(PMAX, 0, 0)});
        e = sb.pop_front();
        checks++;
        if (obs2() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, obs2(), e.v);
        end
        edge_wait();
        reset2 = 1'b0;
        subir2 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            sb.push_back('{$sformatf("subir at top edge %0d", k), mk(PMAX, 0, 0)});
            edge_wait();
            e = sb.pop_front();
            checks++;
            if (obs2() !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, obs2(), e.v);
            end
        end
        subir2 = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        subir  = 1'b0;
        bajar  = 1'b0;
        reset2 = 1'b1;
        subir2 = 1'b0;
        bajar2 = 1'b0;
        #1;
        test_reset();
        test_subida();
        test_bajar_pulso();
        test_inversion();
        test_falla();
        test_limites();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
